vsub_sequencer: RTL and testbench

- Multi-cycle vector subtract controller for the vector ALU.
- Time-shares one internal Full_Subtractor #(W) instance across LANES lanes, one lane per cycle, lane 0 first.
- Two modes:
  - Independent mode: each lane is a separate W-bit subtract with borrow-in 0.
  - Chained mode: the vector is one LANES*W-bit operand. Borrow ripples lane to lane, giving a wide subtract.
- Valid/ready handshakes on input and output. Sits between vector register read and writeback.

---
 rtl/vsub_sequencer.sv | 139 +++++++++++++
 tb/tb_vsub_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vsub_sequencer.sv
//------------------------------------------------------------------------------
// Module   : vsub_sequencer (with internal Full_Subtractor)
// Purpose  : Multi-cycle vector subtract; one shared W-bit subtractor walks
//            LANES lanes, either independently or as one chained wide operand.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module Full_Subtractor #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_bin,
    output logic [W-1:0] o_d,
    output logic         o_bout
);
    // The extra top bit of the widened difference is the borrow-out.
    logic [W:0] w_diff;

    assign w_diff = {1'b0, i_a} - {1'b0, i_b} - {{W{1'b0}}, i_bin};
    assign o_d    = w_diff[W-1:0];
    assign o_bout = w_diff[W];
endmodule

module vsub_sequencer #(
    parameter int W     = 8,
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode,
    input  logic [LANES*W-1:0]   a_vec,
    input  logic [LANES*W-1:0]   b_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   d_vec,
    output logic [LANES-1:0]     bout_vec,
    output logic                 busy
);
    localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDXW-1:0] c_IDX_LAST = IDXW'(LANES - 1);
    localparam logic [IDXW-1:0] c_IDX_ONE  = IDXW'(1);

    logic [1:0]           r_state;
    logic [IDXW-1:0]      r_idx;
    logic                 r_borrow;
    logic                 r_mode;
    logic [LANES*W-1:0]   r_a;
    logic [LANES*W-1:0]   r_b;
    logic [LANES*W-1:0]   r_d;
    logic [LANES-1:0]     r_bout;
    logic                 r_out_valid;

    logic [W-1:0]         w_a_lane;
    logic [W-1:0]         w_b_lane;
    logic                 w_bin;
    logic [W-1:0]         w_d;
    logic                 w_bout;

    assign w_a_lane = r_a[r_idx*W +: W];
    assign w_b_lane = r_b[r_idx*W +: W];
    // Lane 0 never takes a borrow, so one chained op cannot leak into the next.
    assign w_bin    = r_mode & (r_idx != '0) & r_borrow;

    Full_Subtractor #(.W(W)) u_sub (
        .i_a    (w_a_lane),
        .i_b    (w_b_lane),
        .i_bin  (w_bin),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_borrow    <= 1'b0;
            r_mode      <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_d         <= '0;
            r_bout      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a      <= a_vec;
                        r_b      <= b_vec;
                        r_mode   <= mode;
                        r_idx    <= '0;
                        r_borrow <= 1'b0;
                        r_d      <= '0;
                        r_bout   <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_d[r_idx*W +: W] <= w_d;
                    r_bout[r_idx]     <= w_bout;
                    r_borrow          <= w_bout;
                    if (r_idx == c_IDX_LAST) begin
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + c_IDX_ONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign out_valid = r_out_valid;
    assign d_vec     = r_d;
    assign bout_vec  = r_bout;
endmodule

`default_nettype wire

// File: tb/tb_vsub_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_vsub_sequencer
// Purpose  : Scoreboard bench for vsub_sequencer at W=4, LANES=4.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vsub_sequencer;
    localparam int TW = 4;
    localparam int TL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mode = 1'b0;
    logic [15:0]   a_vec = '0;
    logic [15:0]   b_vec = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   d_vec;
    logic [3:0]    bout_vec;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_acc = 0;
    int acc_times[$];
    logic [15:0] q_d[$];
    logic [3:0]  q_b[$];

    vsub_sequencer #(.W(TW), .LANES(TL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a_vec     (a_vec),
        .b_vec     (b_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d_vec     (d_vec),
        .bout_vec  (bout_vec),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready) begin
            last_acc <= cyc + 1;
            acc_times.push_back(cyc + 1);
        end
    end

    // Reference: chained borrow of lane i is "low (i+1) lanes of A < same of B".
    function automatic void model(input logic m, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] d, output logic [3:0] bo);
        logic [16:0] mask;
        if (m) begin
            d = a - b;
            for (int i = 0; i < 4; i++) begin
                mask  = (17'd1 << (4 * (i + 1))) - 17'd1;
                bo[i] = ({1'b0, a} & mask) < ({1'b0, b} & mask);
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                d[4*i +: 4] = a[4*i +: 4] - b[4*i +: 4];
                bo[i]       = a[4*i +: 4] < b[4*i +: 4];
            end
        end
    endfunction

    task automatic drive_op(input logic m, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] ed;
        logic [3:0]  eb;
        int          n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        model(m, a, b, ed, eb);
        q_d.push_back(ed);
        q_b.push_back(eb);
        mode = m; a_vec = a; b_vec = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mode  = ~m;
        a_vec = 16'($urandom);
        b_vec = 16'($urandom);
    endtask

    task automatic wait_out(output int lat, output bit to);
        to  = 1'b1;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - last_acc;
                to  = 1'b0;
                return;
            end
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_tests++; if (d_vec !== 16'h0)    begin n_fail++; $display("FAIL reset_d got=%h exp=0000", d_vec); end
        n_tests++; if (bout_vec !== 4'h0)  begin n_fail++; $display("FAIL reset_bout got=%b exp=0000", bout_vec); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one op through the scoreboard with latency check, then drains it.
    task automatic run_and_check(input string nm, input logic m, input logic [15:0] a,
                                 input logic [15:0] b, input logic [15:0] kd, input logic [3:0] kb);
        int lat; bit to;
        logic [15:0] ed; logic [3:0] eb;
        drive_op(m, a, b);
        wait_out(lat, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL %s_timeout no out_valid", nm); end
        else if (lat !== 4) begin n_fail++; $display("FAIL %s_latency got=%0d exp=4", nm, lat); end
        ed = q_d.pop_front();
        eb = q_b.pop_front();
        n_tests++; if (d_vec !== ed)    begin n_fail++; $display("FAIL %s_d got=%h exp=%h", nm, d_vec, ed); end
        n_tests++; if (bout_vec !== eb) begin n_fail++; $display("FAIL %s_bout got=%b exp=%b", nm, bout_vec, eb); end
        n_tests++; if (d_vec !== kd || bout_vec !== kb)
            begin n_fail++; $display("FAIL %s_known got=%h/%b exp=%h/%b", nm, d_vec, bout_vec, kd, kb); end
        release_out();
    endtask

    task automatic test_independent();
        run_and_check("indep1", 1'b0, 16'h080A, 16'h0A01, 16'h0E09, 4'b0100);
        run_and_check("indep2", 1'b0, 16'h080A, 16'h0AF1, 16'h0E19, 4'b0110);
    endtask

    task automatic test_chained();
        run_and_check("chain", 1'b1, 16'h1000, 16'h0001, 16'h0FFF, 4'b0111);
    endtask

    task automatic test_underflow();
        run_and_check("under", 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 4'b1111);
        run_and_check("equal", 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0000);
    endtask

    task automatic test_backpressure();
        int lat; bit to;
        logic [15:0] ed; logic [3:0] eb;
        drive_op(1'b0, 16'h3C5A, 16'h5A3C);
        wait_out(lat, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL bp_timeout no out_valid"); end
        ed = q_d.pop_front();
        eb = q_b.pop_front();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_valid = 1'b1; mode = 1'b1; a_vec = 16'h1234; b_vec = 16'h4321;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            n_tests++;
            if (d_vec !== ed || bout_vec !== eb || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got d=%h b=%b ov=%b ir=%b busy=%b exp d=%h b=%b ov=1 ir=0 busy=1",
                         i, d_vec, bout_vec, out_valid, in_ready, busy, ed, eb);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release got ov=%b ir=%b busy=%b exp ov=0 ir=1 busy=0", out_valid, in_ready, busy);
        end
        n_tests++;
        if (d_vec !== ed || bout_vec !== eb) begin
            n_fail++;
            $display("FAIL bp_keep got=%h/%b exp=%h/%b", d_vec, bout_vec, ed, eb);
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit to;
        logic [15:0] ed; logic [3:0] eb;
        drive_op(1'b1, 16'hFFFF, 16'h1111);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        void'(q_d.pop_front());
        void'(q_b.pop_front());
        n_tests++;
        if (d_vec !== 16'h0 || bout_vec !== 4'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid got d=%h b=%b ov=%b ir=%b exp d=0000 b=0000 ov=0 ir=1",
                     d_vec, bout_vec, out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_op(1'b0, 16'h1111, 16'h1111);
        wait_out(lat, to);
        ed = q_d.pop_front();
        eb = q_b.pop_front();
        n_tests++;
        if (to || lat !== 4 || d_vec !== ed || d_vec !== 16'h0 || bout_vec !== eb) begin
            n_fail++;
            $display("FAIL rst_after got d=%h b=%b lat=%0d exp d=%h b=%b lat=4", d_vec, bout_vec, lat, ed, eb);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [15:0] ed; logic [3:0] eb;
        int seen;
        bit switched;
        acc_times.delete();
        seen = 0;
        switched = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        model(1'b1, 16'h0000, 16'h0001, ed, eb); q_d.push_back(ed); q_b.push_back(eb);
        mode = 1'b1; a_vec = 16'h0000; b_vec = 16'h0001; in_valid = 1'b1;
        for (int i = 0; i < 60 && seen < 2; i++) begin
            @(negedge clk);
            if (!switched && acc_times.size() == 1) begin
                switched = 1'b1;
                model(1'b1, 16'h0005, 16'h0003, ed, eb); q_d.push_back(ed); q_b.push_back(eb);
                a_vec = 16'h0005; b_vec = 16'h0003;
            end
            if (acc_times.size() >= 2) in_valid = 1'b0;
            if (out_valid) begin
                ed = q_d.pop_front();
                eb = q_b.pop_front();
                n_tests++;
                if (d_vec !== ed || bout_vec !== eb) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d] got=%h/%b exp=%h/%b", seen, d_vec, bout_vec, ed, eb);
                end
                seen++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_tests++;
        if (seen != 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", seen); end
        n_tests++;
        if (acc_times.size() < 2) begin
            n_fail++; $display("FAIL b2b_spacing got=%0d accepts exp=2", acc_times.size());
        end else if (acc_times[1] - acc_times[0] != 6) begin
            n_fail++; $display("FAIL b2b_spacing got=%0d exp=6", acc_times[1] - acc_times[0]);
        end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_chained();
        test_underflow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
